// File: rtl/bdf_sched_pkg.sv
// Shared definitions for the BDF actor scheduler.
// Holds the FSM state type, the code-word field layout, and the default
// parameter values used by bdf_sched and its program store.
package bdf_sched_pkg;

  localparam int unsigned NUM_BUFFERS        = 4;
  localparam int unsigned CODE_WIDTH         = 8;
  localparam int unsigned ITERATION_BOUND    = 8;
  localparam int unsigned PROG_DEPTH_DEFAULT = 16;

  // Buffer-index field width for the default configuration.
  localparam int unsigned BUF_IDX_W = $clog2(NUM_BUFFERS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STALL,
    PAD
  } state_e;

  // Code word layout, MSB first: {rd_buf, wr_buf, op}.
  typedef struct packed {
    logic [BUF_IDX_W-1:0]              rd_buf;
    logic [BUF_IDX_W-1:0]              wr_buf;
    logic [CODE_WIDTH-2*BUF_IDX_W-1:0] op;
  } code_word_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bdf_prog_mem.sv
// Program store for the BDF scheduler.
// One write port, one registered read port, DEPTH x WIDTH. Contents are not
// reset. Read data for raddr_i appears in the cycle after it is presented.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address (sampled every cycle)
//   rdata_o  registered read data
module bdf_prog_mem
  import bdf_sched_pkg::*;
#(
  parameter int unsigned DEPTH = PROG_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = CODE_WIDTH,
  localparam int unsigned AW   = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bdf_sched.sv
// Boolean-dataflow static schedule sequencer.
// Stores a program of code words, then replays it once per iteration of
// ITER_PERIOD cycles, issuing each word only when its read buffer is
// non-empty and its write buffer is non-full. Short programs are padded to
// the iteration period; long or stalled ones overrun it.
// Ports:
//   clk2, rst2  clock, synchronous active-high reset
//   ctrl_in     code word to load          load_ctrl   store ctrl_in
//   start_ctrl  run while high             stop_ctrl   halt at iteration end
//   buf_empty   per-buffer empty flags     buf_full    per-buffer full flags
//   ctrl_out    issued word (0 when idle)  ctrl_valid  word issued this cycle
//   iter_done   last cycle of an iteration busy        not IDLE
//   overrun     sticky iteration overrun   load_err    sticky load overflow
module bdf_sched
  import bdf_sched_pkg::*;
#(
  parameter int unsigned NUM_BUFFS   = NUM_BUFFERS,
  parameter int unsigned CTRL_WIDTH  = CODE_WIDTH,
  parameter int unsigned ITER_PERIOD = ITERATION_BOUND,
  parameter int unsigned PROG_DEPTH  = PROG_DEPTH_DEFAULT
) (
  input  logic                  clk2,
  input  logic                  rst2,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  input  logic                  load_ctrl,
  input  logic                  start_ctrl,
  input  logic                  stop_ctrl,
  input  logic [NUM_BUFFS-1:0]  buf_empty,
  input  logic [NUM_BUFFS-1:0]  buf_full,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  ctrl_valid,
  output logic                  iter_done,
  output logic                  busy,
  output logic                  overrun,
  output logic                  load_err
);

  localparam int unsigned B   = idx_width(NUM_BUFFS);
  localparam int unsigned AW  = idx_width(PROG_DEPTH);
  localparam int unsigned LW  = $clog2(PROG_DEPTH + 1);
  localparam int unsigned CYW = $clog2(ITER_PERIOD + PROG_DEPTH);

  localparam logic [LW-1:0]  DEPTH_L = LW'(PROG_DEPTH);
  localparam logic [CYW-1:0] CYC_MAX = '1;

  state_e          state_q, state_d;
  logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   prog_len_q, prog_len_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CYW-1:0]  cyc_q, cyc_d;
  logic            stop_q, stop_d;
  logic            overrun_q, overrun_d;
  logic            load_err_q, load_err_d;
  logic            busy_q;

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [CTRL_WIDTH-1:0] rd_data;
  logic [B-1:0]          rd_buf;
  logic [B-1:0]          wr_buf;
  logic                  eligible;
  logic                  issue;
  logic                  last_word;
  logic                  iter_end;
  logic [CYW-1:0]        cyc_inc;

  // Reading at the next pc keeps mem[pc] ready in the cycle pc is current,
  // so a registered store still issues with no added latency.
  bdf_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (CTRL_WIDTH)
  ) u_prog_mem (
    .clk_i   (clk2),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (ctrl_in),
    .raddr_i (pc_d),
    .rdata_o (rd_data)
  );

  assign rd_buf    = rd_data[CTRL_WIDTH-1 -: B];
  assign wr_buf    = rd_data[CTRL_WIDTH-1-B -: B];
  assign eligible  = !buf_empty[rd_buf] && !buf_full[wr_buf];
  assign issue     = ((state_q == RUN) || (state_q == STALL)) && eligible;
  assign last_word = ((LW'(pc_q) + 1'b1) == prog_len_q);
  assign cyc_inc   = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    pc_d       = pc_q;
    cyc_d      = cyc_q;
    stop_d     = stop_q;
    overrun_d  = overrun_q;
    load_err_d = load_err_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    iter_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_ctrl) begin
          mem_we     = 1'b1;
          wr_ptr_d   = LW'(1);
          prog_len_d = LW'(1);
          state_d    = LOAD;
        end else if (start_ctrl && !stop_ctrl && (prog_len_q != '0)) begin
          pc_d    = '0;
          cyc_d   = '0;
          state_d = RUN;
        end
      end

      LOAD: begin
        if (load_ctrl) begin
          if (wr_ptr_q == DEPTH_L) begin
            load_err_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            mem_waddr  = wr_ptr_q[AW-1:0];
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prog_len_d = wr_ptr_q + 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN, STALL: begin
        cyc_d  = cyc_inc;
        stop_d = stop_q | stop_ctrl;
        if (issue) begin
          if (last_word) begin
            if ((32'(cyc_q) + 32'd1) < ITER_PERIOD) begin
              state_d = PAD;
            end else begin
              iter_end = 1'b1;
            end
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = RUN;
          end
        end else begin
          state_d = STALL;
        end
      end

      PAD: begin
        cyc_d  = cyc_inc;
        stop_d = stop_q | stop_ctrl;
        if (32'(cyc_q) >= (ITER_PERIOD - 1)) begin
          iter_end = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (iter_end) begin
      pc_d  = '0;
      cyc_d = '0;
      if (32'(cyc_q) >= ITER_PERIOD) begin
        overrun_d = 1'b1;
      end
      // A stop seen in the final cycle still counts for this iteration.
      state_d = (stop_q || stop_ctrl || !start_ctrl) ? IDLE : RUN;
    end

    if (state_d == IDLE) begin
      stop_d = 1'b0;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst2) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      pc_q       <= '0;
      cyc_q      <= '0;
      stop_q     <= 1'b0;
      overrun_q  <= 1'b0;
      load_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      pc_q       <= pc_d;
      cyc_q      <= cyc_d;
      stop_q     <= stop_d;
      overrun_q  <= overrun_d;
      load_err_q <= load_err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // Issue is decided from this cycle's buffer flags, so these outputs are
  // decoded rather than registered; reset masks them in its own cycle.
  assign ctrl_valid = issue && !rst2;
  assign ctrl_out   = ctrl_valid ? rd_data : '0;
  assign iter_done  = iter_end && !rst2;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_bdf_sched.sv
// Randomised scoreboard bench for bdf_sched. The stimulus side plans each
// iteration (per-word stall counts), derives issue cycles, iteration length
// and overrun with plain arithmetic, and queues the expected output events.
// A negedge monitor pops and compares whenever the DUT issues or ends an
// iteration.
module tb_bdf_sched;
  import bdf_sched_pkg::*;

  localparam int IP    = 8;
  localparam int DEPTH = 16;

  logic       clk2 = 1'b0;
  logic       rst2 = 1'b1;
  logic [7:0] ctrl_in = '0;
  logic       load_ctrl = 1'b0;
  logic       start_ctrl = 1'b0;
  logic       stop_ctrl = 1'b0;
  logic [3:0] buf_empty = '0;
  logic [3:0] buf_full = '0;
  logic [7:0] ctrl_out;
  logic       ctrl_valid;
  logic       iter_done;
  logic       busy;
  logic       overrun;
  logic       load_err;

  bdf_sched #(
    .NUM_BUFFS   (4),
    .CTRL_WIDTH  (8),
    .ITER_PERIOD (IP),
    .PROG_DEPTH  (DEPTH)
  ) dut (
    .clk2       (clk2),
    .rst2       (rst2),
    .ctrl_in    (ctrl_in),
    .load_ctrl  (load_ctrl),
    .start_ctrl (start_ctrl),
    .stop_ctrl  (stop_ctrl),
    .buf_empty  (buf_empty),
    .buf_full   (buf_full),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .iter_done  (iter_done),
    .busy       (busy),
    .overrun    (overrun),
    .load_err   (load_err)
  );

  always #5 clk2 = ~clk2;

  int unsigned now = 0;
  always @(posedge clk2) now <= now + 1;

  typedef struct {
    int unsigned cyc;
    bit          done;
    logic [7:0]  word;
  } ev_t;

  ev_t        expq [$];
  ev_t        mon_e;
  logic [7:0] prog [$];
  bit         exp_overrun  = 1'b0;
  bit         exp_load_err = 1'b0;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  task automatic tick;
    @(posedge clk2);
    #1;
  endtask

  // Monitor: compare every presented output against the queued expectation.
  always @(negedge clk2) begin
    if (ctrl_valid) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_issue: got word %0h at cycle %0d expected none", ctrl_out, now);
      end else begin
        mon_e = expq.pop_front();
        chk("issue_kind", 32'(mon_e.done), 32'd0);
        chk("issue_cycle", now, mon_e.cyc);
        chk("issue_word", 32'(ctrl_out), 32'(mon_e.word));
      end
    end else begin
      chk("ctrl_out_zero_when_invalid", 32'(ctrl_out), 32'd0);
    end
    if (iter_done) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_iter_done: got pulse at cycle %0d expected none", now);
      end else begin
        mon_e = expq.pop_front();
        chk("iter_done_kind", 32'(mon_e.done), 32'd1);
        chk("iter_done_cycle", now, mon_e.cyc);
      end
    end
    if (expq.size() > 0 && expq[0].cyc < now) begin
      mon_e = expq.pop_front();
      total++; bad++;
      $display("FAIL missed_event: done=%0d word %0h due cycle %0d not seen by cycle %0d",
               mon_e.done, mon_e.word, mon_e.cyc, now);
    end
  end

  task automatic do_reset;
    rst2 = 1'b1;
    tick;
    rst2 = 1'b0;
    prog.delete();
    exp_overrun  = 1'b0;
    exp_load_err = 1'b0;
  endtask

  task automatic load_words(input logic [7:0] ws [$]);
    prog.delete();
    foreach (ws[i]) begin
      ctrl_in   = ws[i];
      load_ctrl = 1'b1;
      if (i < DEPTH) prog.push_back(ws[i]);
      else exp_load_err = 1'b1;
      tick;
    end
    load_ctrl = 1'b0;
    ctrl_in   = '0;
    tick;
  endtask

  // mode 0: all buffers ready; 1: random flags and stalls;
  // 2: word 1 held back 4 cycles by its read buffer being empty.
  task automatic set_flags(input int idx, input bit blocked, input int mode);
    logic [3:0] e, f;
    logic [1:0] r, w;
    e = (mode == 1) ? 4'($urandom) : 4'h0;
    f = (mode == 1) ? 4'($urandom) : 4'h0;
    if (idx >= 0) begin
      r = prog[idx][7:6];
      w = prog[idx][5:4];
      e[r] = 1'b0;
      f[w] = 1'b0;
      if (blocked) begin
        if (mode == 2 || $urandom_range(0, 1) == 0) e[r] = 1'b1;
        else f[w] = 1'b1;
      end
    end
    buf_empty = e;
    buf_full  = f;
  endtask

  // stop_iter < 0 ends the run by dropping start_ctrl in the final cycle.
  task automatic run(input int n_iter, input int mode, input int stop_iter, input int stop_off);
    int base, T, L, sk;
    int plan_idx [$];
    bit plan_blk [$];
    start_ctrl = 1'b1;
    for (int it = 0; it < n_iter; it++) begin
      base = int'(now) + 1;
      plan_idx.delete();
      plan_blk.delete();
      for (int k = 0; k < prog.size(); k++) begin
        if (mode == 1) sk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        else if (mode == 2 && k == 1) sk = 4;
        else sk = 0;
        for (int j = 0; j < sk; j++) begin
          plan_idx.push_back(k);
          plan_blk.push_back(1'b1);
        end
        expq.push_back('{int'(base + plan_idx.size()), 1'b0, prog[k]});
        plan_idx.push_back(k);
        plan_blk.push_back(1'b0);
      end
      T = plan_idx.size();
      L = (T > IP) ? T : IP;
      if (T > IP) exp_overrun = 1'b1;
      while (plan_idx.size() < L) begin
        plan_idx.push_back(-1);
        plan_blk.push_back(1'b0);
      end
      expq.push_back('{int'(base + L - 1), 1'b1, 8'h00});
      for (int c = 0; c < L; c++) begin
        tick;
        set_flags(plan_idx[c], plan_blk[c], mode);
        stop_ctrl = (it == stop_iter && c == stop_off);
        if (stop_iter < 0 && it == n_iter - 1 && c == L - 1) start_ctrl = 1'b0;
      end
    end
    tick;
    stop_ctrl  = 1'b0;
    start_ctrl = 1'b0;
    buf_empty  = '0;
    buf_full   = '0;
    chk("busy_after_last_iteration", 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0] rand_word();
    code_word_t cw;
    cw = code_word_t'(8'($urandom));
    return cw;
  endfunction

  initial begin
    logic [7:0] ws [$];
    code_word_t cw;
    int base;

    repeat (3) tick;
    rst2 = 1'b0;
    tick;
    chk("reset_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("reset_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("reset_iter_done", 32'(iter_done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_load_err", 32'(load_err), 32'd0);

    // Start with an empty program: nothing happens.
    start_ctrl = 1'b1;
    repeat (5) begin
      tick;
      chk("empty_prog_busy", 32'(busy), 32'd0);
    end
    start_ctrl = 1'b0;
    tick;

    // Five words, all buffers ready: 5 issues, 3 pad, repeating every 8.
    ws.delete();
    repeat (5) ws.push_back(rand_word());
    load_words(ws);
    chk("load5_load_err", 32'(load_err), 32'(exp_load_err));
    run(3, 0, -1, 0);
    chk("load5_overrun", 32'(overrun), 32'(exp_overrun));

    // start and stop together in IDLE keep the block idle.
    start_ctrl = 1'b1;
    stop_ctrl  = 1'b1;
    repeat (3) begin
      tick;
      chk("start_with_stop_busy", 32'(busy), 32'd0);
    end
    start_ctrl = 1'b0;
    stop_ctrl  = 1'b0;
    tick;

    // stop pulsed at cycle 3 of the second iteration finishes that iteration.
    run(2, 0, 1, 3);
    repeat (4) tick;
    chk("after_stop_busy", 32'(busy), 32'd0);

    // Word 1 reads buffer 2, held empty for 4 cycles: 9 cycles, overrun.
    do_reset;
    ws.delete();
    repeat (5) ws.push_back(rand_word());
    cw = code_word_t'(ws[1]);
    cw.rd_buf = 2'd2;
    ws[1] = cw;
    load_words(ws);
    run(1, 2, -1, 0);
    tick;
    chk("stall_overrun", 32'(overrun), 32'(exp_overrun));

    // 17 loads: the last is dropped and flagged; a run issues exactly 16.
    do_reset;
    ws.delete();
    for (int i = 0; i < 17; i++) ws.push_back(8'(i * 13 + 5));
    load_words(ws);
    chk("overflow_load_err", 32'(load_err), 32'(exp_load_err));
    run(1, 0, -1, 0);
    tick;
    chk("long_prog_overrun", 32'(overrun), 32'(exp_overrun));
    chk("load_err_sticky", 32'(load_err), 32'd1);

    // Reset while issuing pc=2: outputs clear, program unreachable until reload.
    do_reset;
    ws.delete();
    repeat (5) ws.push_back(rand_word());
    load_words(ws);
    start_ctrl = 1'b1;
    buf_empty  = '0;
    buf_full   = '0;
    base = int'(now) + 1;
    expq.push_back('{base, 1'b0, prog[0]});
    expq.push_back('{base + 1, 1'b0, prog[1]});
    tick;
    tick;
    tick;
    rst2 = 1'b1;
    tick;
    rst2 = 1'b0;
    chk("midrun_reset_valid", 32'(ctrl_valid), 32'd0);
    chk("midrun_reset_out", 32'(ctrl_out), 32'd0);
    chk("midrun_reset_done", 32'(iter_done), 32'd0);
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_overrun", 32'(overrun), 32'd0);
    chk("midrun_reset_load_err", 32'(load_err), 32'd0);
    repeat (4) begin
      tick;
      chk("no_restart_without_reload", 32'(busy), 32'd0);
    end
    start_ctrl = 1'b0;
    tick;
    load_words(ws);
    run(1, 0, -1, 0);

    // Random programs, random buffer flags and stalls.
    do_reset;
    for (int p = 0; p < 6; p++) begin
      ws.delete();
      repeat ($urandom_range(1, 12)) ws.push_back(rand_word());
      load_words(ws);
      if ($urandom_range(0, 1) == 0) begin
        run(int'($urandom_range(2, 4)), 1, -1, 0);
      end else begin
        base = int'($urandom_range(1, 3));
        run(base, 1, base - 1, int'($urandom_range(0, 6)));
      end
      tick;
      chk("random_overrun", 32'(overrun), 32'(exp_overrun));
      chk("random_load_err", 32'(load_err), 32'(exp_load_err));
    end

    repeat (3) tick;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bdf_sched.md
BDF_SCHED -- requirements
Module: bdf_sched

Interface
REQ-001 Parameter NUM_BUFFS, default 4, number of inter-actor token buffers.
REQ-002 Parameter CTRL_WIDTH, default 8, code-word width.
REQ-003 Parameter ITER_PERIOD, default 8, cycles per schedule iteration.
REQ-004 Parameter PROG_DEPTH, default 16, maximum code words stored.
REQ-005 The block SHALL use one clock, clk2, with synchronous active-high reset rst2.
REQ-006 The block SHALL provide these ports:
- clk2  in  1  clock.
- rst2  in  1  synchronous active-high reset.
- ctrl_in  in  CTRL_WIDTH  code word to load.
- load_ctrl  in  1  write ctrl_in into program store.
- start_ctrl  in  1  level; run schedule while high.
- stop_ctrl  in  1  request halt at iteration boundary.
- buf_empty  in  NUM_BUFFS  per-buffer empty flags.
- buf_full  in  NUM_BUFFS  per-buffer full flags.
- ctrl_out  out  CTRL_WIDTH  issued code word.
- ctrl_valid  out  1  ctrl_out fires this cycle.
- iter_done  out  1  one-cycle pulse at iteration end.
- busy  out  1  state is not IDLE.
- overrun  out  1  sticky; an iteration exceeded ITER_PERIOD.
- load_err  out  1  sticky; load beyond PROG_DEPTH.

Function
REQ-007 Code word fields SHALL be {rd_buf[B-1:0], wr_buf[B-1:0], op[CTRL_WIDTH-2B-1:0]}, MSB first, where B=clog2(NUM_BUFFS).
REQ-008 The states SHALL be IDLE, LOAD, RUN, STALL and PAD.
REQ-009 IDLE->LOAD on load_ctrl: the write pointer clears, prog_len clears and the word is stored at address 0.
REQ-010 In LOAD, each load_ctrl cycle SHALL store at wr_ptr++ and set prog_len=wr_ptr+1.
- Load deasserted SHALL return the FSM to IDLE.
REQ-011 A load with wr_ptr==PROG_DEPTH SHALL be dropped and set load_err.
REQ-012 load_ctrl SHALL be ignored in RUN, STALL and PAD.
REQ-013 IDLE->RUN SHALL occur on start_ctrl=1 with prog_len>0 and load_ctrl=0.
- With prog_len==0 the FSM SHALL remain in IDLE.
- The program counter pc and the cycle counter cyc SHALL clear on this transition.
REQ-014 In RUN, a word is eligible when buf_empty[rd_buf]==0 and buf_full[wr_buf]==0.
- Eligible: ctrl_out=mem[pc] and ctrl_valid=1 in the same cycle (registered store read, zero added latency), then pc++.
- Not eligible: the FSM SHALL go to STALL with ctrl_valid=0.
REQ-015 STALL SHALL return to RUN in the cycle the eligibility condition holds, issuing the word in that cycle.
REQ-016 cyc SHALL increment every cycle in RUN, STALL and PAD, saturating at 2^clog2(ITER_PERIOD+PROG_DEPTH)-1.
REQ-017 After the word at pc==prog_len-1 issues:
- If cyc+1<ITER_PERIOD, the FSM SHALL go to PAD with ctrl_valid=0 until cyc==ITER_PERIOD-1.
- Otherwise the iteration SHALL end immediately.
REQ-018 At iteration end, iter_done SHALL pulse for one cycle and pc and cyc SHALL clear.
- The next state SHALL be IDLE if stop_ctrl has been seen since iteration start or start_ctrl==0; otherwise RUN.
REQ-019 An iteration ending with cyc>=ITER_PERIOD SHALL set overrun.
- prog_len>ITER_PERIOD therefore overruns every iteration.
REQ-020 stop_ctrl SHALL be latched and SHALL never truncate an iteration in progress.
- It SHALL clear on entry to IDLE.
- stop_ctrl and start_ctrl asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-021 ctrl_out SHALL hold 0 whenever ctrl_valid==0.
REQ-022 load_err and overrun SHALL clear only on rst2.

Reset
REQ-023 rst2 SHALL force state=IDLE and clear wr_ptr, prog_len, pc, cyc and the stop latch.
- rst2 SHALL drive ctrl_out=0, ctrl_valid=0, iter_done=0, busy=0, overrun=0 and load_err=0.
REQ-024 Program store contents SHALL be left unchanged by reset, but prog_len=0 makes them unreachable.
REQ-025 rst2 mid-RUN SHALL abort with no iter_done pulse.

Structure
REQ-026 The shared defines package SHALL hold:
- the state enum type;
- the code-word field struct;
- NUM_BUFFERS, CODE_WIDTH and ITERATION_BOUND defaults.
REQ-027 The program store SHALL be one sub-module, bdf_prog_mem: single write port, single read port, PROG_DEPTH x CTRL_WIDTH.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Load 5 words, start with all buffers ready and empty=0: 5 consecutive ctrl_valid cycles, 3 pad cycles, iter_done at cycle 8, repeating every 8.
- Hold buf_empty[2]=1 for 4 cycles on a word with rd_buf=2: ctrl_valid=0 for those 4 cycles; the word issues when the flag drops; 5+4=9>8 cycles so overrun=1.
- Load 17 words: store holds 16, prog_len=16, load_err=1.
- Pulse stop_ctrl at cycle 3 of an iteration: the iteration completes, iter_done pulses, busy=0 the next cycle, no further ctrl_valid.
- Assert rst2 mid-RUN at pc=2: the next cycle shows all outputs 0 and state IDLE; restarting issues from pc=0 only after a reload.
- Start with prog_len=0: busy stays 0 and ctrl_valid stays 0.
